gmii_rx_framer: RTL
===================

Name: gmii_rx_framer

Overview:
- Receive-side framer sitting directly upstream of the parallel FCS checker.
- Takes a byte-wide GMII-style receive stream (rx_dv/rx_er/rx_data), strips preamble and SFD, and delays the frame by 4 bytes so it can flag the first FCS byte.
- Emits the frame byte stream with start_of_frame on byte 0 and end_of_frame on the first FCS byte, which is exactly the framing the FCS checker consumes.
- Also reports frame length and framing errors per frame.

Parameters:
MIN_FRAME_LEN, 64, minimum legal frame length in bytes, DA through FCS inclusive
MAX_FRAME_LEN, 1518, maximum legal frame length in bytes, DA through FCS inclusive
LEN_W, 11, width of frame_len; the length counter saturates at 2^LEN_W-1

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
rx_dv  in  1  receive data valid; contiguous for the duration of preamble plus frame
rx_er  in  1  receive error strobe
rx_data  in  8  receive byte
data_out  out  8  frame byte (DA onward, including FCS)
data_valid  out  1  data_out holds a frame byte
start_of_frame  out  1  high with frame byte 0
end_of_frame  out  1  high with the first FCS byte (length-4)
frame_done  out  1  one-cycle pulse, the cycle after the last FCS byte
frame_len  out  LEN_W  byte count of the frame; valid with frame_done
frame_error  out  1  valid with frame_done: runt, giant, or rx_er seen

Behaviour:
- Reset (async): every output is 0, the FSM is in IDLE, and all delay-line valid bits are cleared. Reset mid-frame abandons the frame with no frame_done; the next frame needs a fresh SFD.
- All outputs are registered.
- FSM states: IDLE, PREAMBLE, FRAME, FLUSH, DROP.
- IDLE transitions:
  - rx_dv & rx_data==8'h55 -> PREAMBLE.
  - rx_dv & rx_data==8'hD5 -> FRAME (short preamble accepted).
  - rx_dv with any other byte -> DROP.
- PREAMBLE transitions:
  - 8'h55 -> stay.
  - 8'hD5 -> FRAME.
  - any other byte -> DROP.
  - rx_dv low -> IDLE.
- DROP: wait for rx_dv low, then -> IDLE. No outputs are produced.
- FRAME:
  - Each rx_dv byte shifts into a 4-entry delay line and increments the length counter (saturating).
  - Byte k appears on data_out, with data_valid=1, in the cycle after byte k+4 is sampled.
  - start_of_frame is asserted with byte 0.
  - rx_dv sampled low -> FLUSH.
- FLUSH: the 4 held bytes (the FCS) are output on 4 consecutive cycles, continuing the cadence with no bubble. end_of_frame is asserted with the first of them.
- The cycle after the last FCS byte:
  - frame_done=1 for one cycle.
  - frame_len = bytes received after the SFD.
  - frame_error = (len<MIN_FRAME_LEN) | (len>MAX_FRAME_LEN) | (rx_er sampled high in any FRAME cycle).
  - FSM -> IDLE.
- Frame of 1-4 bytes: no data_valid, start_of_frame, or end_of_frame is emitted. frame_done and frame_error=1 pulse the cycle after rx_dv drops, with frame_len = actual count.
- Frame of exactly 5 bytes: start_of_frame and end_of_frame fall on consecutive cycles.
- Giant frames are still passed through in full; only frame_error flags them.
- FLUSH ignores rx_dv. If rx_dv is high in the last FLUSH cycle (IPG violation), the next state is DROP instead of IDLE. If rx_dv is low in that cycle, the next state is IDLE.
- start_of_frame and end_of_frame are never asserted without data_valid.

Decomposition:
- Package rx_framer_pkg:
  - PREAMBLE_BYTE = 8'h55 and SFD_BYTE = 8'hD5.
  - Enum typedef for the FSM states.
  - Default MIN/MAX frame-length constants.
- One natural sub-module, rx_byte_delay_line: a 4-deep shift register of {byte, valid}.
  - Inputs: shift enable, byte in, valid in.
  - Output: the oldest entry.
  - During FLUSH it shifts in invalid entries.

Test Plan:
- Good 64-byte frame: 7x55, D5, then 00 10 A4 7B ... 10 11 E6 C5 3D B2. Required response:
  - start_of_frame with data_out=00, 4 cycles after the first DA byte is sampled.
  - 64 contiguous data_valid cycles.
  - end_of_frame with data_out=E6.
  - Last byte B2.
  - frame_done with frame_len=64, frame_error=0.
  - Chaining to fcs_check_parallel gives fcs_error=0.
- Same frame with rx_er pulsed on byte 15: the 64 bytes are still passed, and frame_done shows frame_error=1, frame_len=64.
- Preamble corrupted (55 55 57 ...): no data_valid and no frame_done. A following good frame after rx_dv low is received normally.
- Runt frames:
  - 3-byte frame: no data_valid; frame_done with frame_len=3, frame_error=1.
  - 5-byte frame: start_of_frame and end_of_frame on consecutive cycles; frame_len=5, frame_error=1.
- 1519-byte frame -> all 1519 bytes out, frame_len=1519, frame_error=1.
- Reset asserted at byte 30 of a good frame -> all outputs 0 immediately, no frame_done. Frame restarted mid-stream without an SFD is ignored. Next full frame passes with frame_len=64, frame_error=0.

Source files
------------

// File: rtl/rx_framer_pkg.sv
`default_nettype none
// ============================================================================
// rx_framer_pkg : shared constants and types for the GMII receive framer
// Rev 1.0
// ============================================================================
package rx_framer_pkg;

    localparam logic [7:0] PREAMBLE_BYTE         = 8'h55;
    localparam logic [7:0] SFD_BYTE              = 8'hD5;
    localparam int         DEFAULT_MIN_FRAME_LEN = 64;
    localparam int         DEFAULT_MAX_FRAME_LEN = 1518;
    localparam int         DELAY_DEPTH           = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_FRAME    = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_DROP     = 3'd4
    } framer_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } dl_entry_t;

endpackage
`default_nettype wire

// File: rtl/rx_byte_delay_line.sv
`default_nettype none
// ============================================================================
// rx_byte_delay_line : 4-deep {byte, valid} shift register holding the FCS
// Rev 1.0
// ============================================================================
module rx_byte_delay_line
    import rx_framer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [7:0] byte_in,
    input  logic       valid_in,
    output logic [7:0] oldest_byte,
    output logic       oldest_valid
);

    dl_entry_t [DELAY_DEPTH-1:0] entries_q;
    dl_entry_t [DELAY_DEPTH-1:0] entries_d;
    dl_entry_t                   new_entry;

    always_comb begin
        new_entry.data  = valid_in ? byte_in : 8'h00;
        new_entry.valid = valid_in;
        entries_d       = entries_q;
        if (clear) begin
            entries_d = '0;
        end else if (shift_en) begin
            entries_d = {entries_q[DELAY_DEPTH-2:0], new_entry};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    assign oldest_byte  = entries_q[DELAY_DEPTH-1].data;
    assign oldest_valid = entries_q[DELAY_DEPTH-1].valid;

endmodule
`default_nettype wire

// File: rtl/gmii_rx_framer.sv
`default_nettype none
// ============================================================================
// gmii_rx_framer : strips preamble/SFD, delays frame 4 bytes to mark the FCS
// Rev 1.0
// ============================================================================
module gmii_rx_framer
    import rx_framer_pkg::*;
#(
    parameter int MIN_FRAME_LEN = DEFAULT_MIN_FRAME_LEN,
    parameter int MAX_FRAME_LEN = DEFAULT_MAX_FRAME_LEN,
    parameter int LEN_W         = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_dv,
    input  logic             rx_er,
    input  logic [7:0]       rx_data,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic             start_of_frame,
    output logic             end_of_frame,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_error
);

    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);
    localparam logic [LEN_W-1:0] SOF_LEN = LEN_W'(DELAY_DEPTH);

    framer_state_t    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             er_seen_q, er_seen_d;
    logic [1:0]       flush_cnt_q, flush_cnt_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             frame_done_q, frame_done_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic             frame_error_q, frame_error_d;

    logic             dl_clear, dl_shift, dl_valid_in;
    logic [7:0]       dl_oldest_byte;
    logic             dl_oldest_valid;
    logic             sfd_start;

    rx_byte_delay_line u_delay (
        .clk          (clk),
        .reset        (reset),
        .clear        (dl_clear),
        .shift_en     (dl_shift),
        .byte_in      (rx_data),
        .valid_in     (dl_valid_in),
        .oldest_byte  (dl_oldest_byte),
        .oldest_valid (dl_oldest_valid)
    );

    function automatic logic frame_bad(input logic [LEN_W-1:0] len, input logic er);
        return (len < MIN_LEN) || (len > MAX_LEN) || er;
    endfunction

    assign sfd_start = rx_dv && (rx_data == SFD_BYTE) &&
                       ((state_q == ST_IDLE) || (state_q == ST_PREAMBLE));

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        er_seen_d     = er_seen_q;
        flush_cnt_d   = flush_cnt_q;
        data_out_d    = 8'h00;
        data_valid_d  = 1'b0;
        sof_d         = 1'b0;
        eof_d         = 1'b0;
        frame_done_d  = 1'b0;
        frame_len_d   = frame_len_q;
        frame_error_d = frame_error_q;
        dl_clear      = 1'b0;
        dl_shift      = 1'b0;
        dl_valid_in   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_dv) begin
                    if (rx_data == PREAMBLE_BYTE)  state_d = ST_PREAMBLE;
                    else if (rx_data != SFD_BYTE)  state_d = ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!rx_dv)                                          state_d = ST_IDLE;
                else if (rx_data != PREAMBLE_BYTE && !sfd_start)     state_d = ST_DROP;
            end
            ST_FRAME: begin
                er_seen_d = er_seen_q | rx_er;
                if (rx_dv) begin
                    dl_shift     = 1'b1;
                    dl_valid_in  = 1'b1;
                    if (len_q != '1) len_d = len_q + 1'b1;
                    data_valid_d = dl_oldest_valid;
                    data_out_d   = dl_oldest_byte;
                    sof_d        = dl_oldest_valid && (len_q == SOF_LEN);
                end else if (len_q > SOF_LEN) begin
                    // Oldest held byte is the first FCS byte; keep cadence into FLUSH
                    dl_shift     = 1'b1;
                    data_valid_d = 1'b1;
                    data_out_d   = dl_oldest_byte;
                    eof_d        = 1'b1;
                    flush_cnt_d  = 2'd0;
                    state_d      = ST_FLUSH;
                end else begin
                    frame_done_d  = 1'b1;
                    frame_len_d   = len_q;
                    frame_error_d = frame_bad(len_q, er_seen_d);
                    state_d       = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 2'd3) begin
                    frame_done_d  = 1'b1;
                    frame_len_d   = len_q;
                    frame_error_d = frame_bad(len_q, er_seen_q);
                    state_d       = rx_dv ? ST_DROP : ST_IDLE;
                end else begin
                    dl_shift     = 1'b1;
                    data_valid_d = dl_oldest_valid;
                    data_out_d   = dl_oldest_byte;
                    flush_cnt_d  = flush_cnt_q + 2'd1;
                end
            end
            ST_DROP: begin
                if (!rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (sfd_start) begin
            state_d   = ST_FRAME;
            len_d     = '0;
            er_seen_d = 1'b0;
            dl_clear  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            er_seen_q     <= 1'b0;
            flush_cnt_q   <= 2'd0;
            data_out_q    <= 8'h00;
            data_valid_q  <= 1'b0;
            sof_q         <= 1'b0;
            eof_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_len_q   <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            er_seen_q     <= er_seen_d;
            flush_cnt_q   <= flush_cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            sof_q         <= sof_d;
            eof_q         <= eof_d;
            frame_done_q  <= frame_done_d;
            frame_len_q   <= frame_len_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_valid     = data_valid_q;
    assign start_of_frame = sof_q;
    assign end_of_frame   = eof_q;
    assign frame_done     = frame_done_q;
    assign frame_len      = frame_len_q;
    assign frame_error    = frame_error_q;

endmodule
`default_nettype wire
